// File: rtl/pipe_wb_regfile.sv
// Write-back stage register file: selects the W-stage datum, commits it to a
// 32x32 register file (r0 hardwired to zero), serves two asynchronous read
// ports with same-cycle write-through bypass, and counts committed writes.
module pipe_wb_regfile #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wwreg,
    input  logic             wm2reg,
    input  logic [31:0]      wmo,
    input  logic [31:0]      walu,
    input  logic [4:0]       wrn,
    input  logic [4:0]       rna,
    input  logic [4:0]       rnb,
    output logic [31:0]      qa,
    output logic [31:0]      qb,
    output logic [31:0]      wdi,
    output logic [CNT_W-1:0] wb_count
);

    logic [31:0]      regs [32];
    logic [CNT_W-1:0] cnt_q;
    logic             we;

    // Write-back datum mux and commit enable; resetn in we also kills the bypass in reset
    always_comb begin
        wdi = wm2reg ? wmo : walu;
        we  = resetn & wwreg & (wrn != 5'd0);
    end

    // Register file storage; entry 0 is held at zero and never written
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we) begin
            regs[wrn] <= wdi;
        end
    end

    // Read ports: r0 reads zero, a committing write to the same register is bypassed
    always_comb begin
        qa = 32'd0;
        qb = 32'd0;
        if (resetn) begin
            if (rna != 5'd0) begin
                qa = (we && (wrn == rna)) ? wdi : regs[rna];
            end
            if (rnb != 5'd0) begin
                qb = (we && (wrn == rnb)) ? wdi : regs[rnb];
            end
        end
    end

    // Committed-write counter, saturating at all-ones
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (we && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wb_count = cnt_q;

endmodule
